// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/func constants, datapath select codes and the decoded-op record.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_JR     = 2'd3;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_ZEXT = 2'd2;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        IC_RALU, IC_JR, IC_IALU, IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic       illegal;
        logic [3:0] alu_op;
        logic [1:0] alu_src_b;
    } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller side.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] fault;
    logic [2:0] state;

    modport master (
        input  opcode, func, zero, mem_ready,
        output pc_we, pc_src, ir_we, mem_re, mem_we, alu_op, alu_src_b,
               reg_we, reg_dst, wb_sel, fault, state
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  pc_we, pc_src, ir_we, mem_re, mem_we, alu_op, alu_src_b,
               reg_we, reg_dst, wb_sel, fault, state
    );
endinterface

// File: rtl/ctrl_op_decode.sv
// Maps opcode/func to an instruction class, ALU operation and B-operand
// select; flags anything outside the supported subset as illegal.
module ctrl_op_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output dec_t       o_dec
);

    // Pure table lookup; func only matters for R-type.
    always_comb begin
        o_dec.cls       = IC_RALU;
        o_dec.illegal   = 1'b0;
        o_dec.alu_op    = ALU_ADD;
        o_dec.alu_src_b = SRCB_RT;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADDU: o_dec.alu_op = ALU_ADD;
                    FN_SUBU: o_dec.alu_op = ALU_SUB;
                    FN_AND:  o_dec.alu_op = ALU_AND;
                    FN_OR:   o_dec.alu_op = ALU_OR;
                    FN_SLT:  o_dec.alu_op = ALU_SLT;
                    FN_SLL:  o_dec.alu_op = ALU_SLL;
                    FN_JR:   o_dec.cls    = IC_JR;
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            OP_ADDIU: begin o_dec.cls = IC_IALU; o_dec.alu_src_b = SRCB_SEXT; end
            OP_ORI:   begin o_dec.cls = IC_IALU; o_dec.alu_op = ALU_OR;  o_dec.alu_src_b = SRCB_ZEXT; end
            OP_LUI:   begin o_dec.cls = IC_IALU; o_dec.alu_op = ALU_LUI; o_dec.alu_src_b = SRCB_ZEXT; end
            OP_LW:    begin o_dec.cls = IC_LW;   o_dec.alu_src_b = SRCB_SEXT; end
            OP_SW:    begin o_dec.cls = IC_SW;   o_dec.alu_src_b = SRCB_SEXT; end
            OP_BEQ:   begin o_dec.cls = IC_BEQ;  o_dec.alu_op = ALU_SUB; end
            OP_J:     o_dec.cls = IC_J;
            OP_JAL:   o_dec.cls = IC_JAL;
            default:  o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory
// wait watchdog and a sticky fault code.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic [1:0]        r_fault, w_fault_nxt;
    logic              r_rst_q;
    dec_t              w_dec;
    logic              w_tmo;
    logic              w_pc_we, w_ir_we, w_mem_re, w_mem_we, w_reg_we;
    logic [1:0]        w_pc_src, w_alu_src_b, w_reg_dst, w_wb_sel;
    logic [3:0]        w_alu_op;

    ctrl_op_decode u_dec (
        .i_opcode (bus.opcode),
        .i_func   (bus.func),
        .o_dec    (w_dec)
    );

    // The MAX-th consecutive stalled cycle is the last one with a strobe;
    // the counter "reaches" MAX in the HALT state that follows.
    assign w_tmo = !bus.mem_ready && (r_wait == WAIT_W'(MEM_WAIT_MAX - 1));

    // State, wait counter, fault and reset-echo registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_fault <= FLT_NONE;
            r_rst_q <= 1'b1;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            r_fault <= w_fault_nxt;
            r_rst_q <= 1'b0;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next      = r_state;
        w_wait_nxt  = '0;
        w_fault_nxt = r_fault;
        w_pc_we     = 1'b0;
        w_pc_src    = PC_PLUS4;
        w_ir_we     = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_alu_op    = ALU_ADD;
        w_alu_src_b = SRCB_RT;
        w_reg_we    = 1'b0;
        w_reg_dst   = RD_RT;
        w_wb_sel    = WB_ALU;
        case (r_state)
            S_FETCH: begin
                w_mem_re = 1'b1;
                // First cycle after reset: read is issued but never completes,
                // so no enable can fire in the cycle after reset.
                if (!r_rst_q) begin
                    if (bus.mem_ready) begin
                        w_ir_we = 1'b1;
                        w_pc_we = 1'b1;
                        w_next  = S_DECODE;
                    end else if (w_tmo) begin
                        w_next      = S_HALT;
                        w_fault_nxt = FLT_TIMEOUT;
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (w_dec.illegal) begin
                    w_next      = S_HALT;
                    w_fault_nxt = FLT_ILLEGAL;
                end else if (w_dec.cls == IC_J) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = PC_JUMP;
                    w_next   = S_FETCH;
                end else if (w_dec.cls == IC_JAL) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_op    = w_dec.alu_op;
                w_alu_src_b = w_dec.alu_src_b;
                case (w_dec.cls)
                    IC_BEQ: begin
                        w_pc_we  = bus.zero;
                        w_pc_src = PC_BRANCH;
                        w_next   = S_FETCH;
                    end
                    IC_JR: begin
                        w_pc_we  = 1'b1;
                        w_pc_src = PC_JR;
                        w_next   = S_FETCH;
                    end
                    IC_LW, IC_SW: w_next = S_MEM;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_re = (w_dec.cls == IC_LW);
                w_mem_we = (w_dec.cls == IC_SW);
                if (bus.mem_ready) begin
                    w_next = (w_dec.cls == IC_LW) ? S_WB : S_FETCH;
                end else if (w_tmo) begin
                    w_next      = S_HALT;
                    w_fault_nxt = FLT_TIMEOUT;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_next   = S_FETCH;
                case (w_dec.cls)
                    IC_RALU: w_reg_dst = RD_RD;
                    IC_LW:   w_wb_sel  = WB_MEM;
                    IC_JAL: begin
                        w_reg_dst = RD_R31;
                        w_wb_sel  = WB_PC4;
                        w_pc_we   = 1'b1;
                        w_pc_src  = PC_JUMP;
                    end
                    default: ;
                endcase
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
        // Reset beats whatever the current state would request.
        if (rst) begin
            w_pc_we  = 1'b0;
            w_ir_we  = 1'b0;
            w_mem_re = 1'b0;
            w_mem_we = 1'b0;
            w_reg_we = 1'b0;
        end
    end

    assign bus.pc_we     = w_pc_we;
    assign bus.pc_src    = w_pc_src;
    assign bus.ir_we     = w_ir_we;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.reg_we    = w_reg_we;
    assign bus.reg_dst   = w_reg_dst;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.fault     = r_fault;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random-instruction bench: each instruction expands into a per-cycle plan
// of expected phases (from the latency/wait rules), which is then played
// against the controller with outputs checked every cycle.
module tb_multicycle_ctrl;

    localparam int WAITMAX = 15;
    localparam int K_RALU = 0, K_JR = 1, K_IALU = 2, K_LW = 3, K_SW = 4,
                   K_BEQ = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        int ph;
        bit mr;
        int flt;
    } step_t;
    step_t plan[$];

    // {opcode, func}; func of I/J entries is replaced by garbage at use.
    logic [11:0] legal [14] = '{12'h021, 12'h023, 12'h024, 12'h025, 12'h02A,
                                12'h000, 12'h008, 12'h240, 12'h340, 12'h3C0,
                                12'h8C0, 12'hAC0, 12'h100, 12'h080};

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_WAIT_MAX(WAITMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    function automatic int kind(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00: return K_RALU;
                    6'h08:   return K_JR;
                    default: return K_ILL;
                endcase
            end
            6'h09, 6'h0D, 6'h0F: return K_IALU;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // {alu_op, alu_src_b} the EXEC cycle must present.
    function automatic logic [5:0] exp_alu(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h21:   return {4'd0, 2'd0};
                    6'h23:   return {4'd1, 2'd0};
                    6'h24:   return {4'd2, 2'd0};
                    6'h25:   return {4'd3, 2'd0};
                    6'h2A:   return {4'd4, 2'd0};
                    default: return {4'd5, 2'd0};
                endcase
            end
            6'h09:        return {4'd0, 2'd1};
            6'h0D:        return {4'd3, 2'd2};
            6'h0F:        return {4'd6, 2'd2};
            6'h23, 6'h2B: return {4'd0, 2'd1};
            default:      return {4'd1, 2'd0};
        endcase
    endfunction

    // Select fields are only meaningful while their enable is high.
    function automatic logic [21:0] mk(logic [2:0] st, logic [1:0] flt,
        logic pcwe, logic irwe, logic mre, logic mwe, logic rwe,
        logic [1:0] pcs, logic [3:0] aop, logic [1:0] asb,
        logic [1:0] rd, logic [1:0] wbs, logic show);
        return {st, flt, pcwe, irwe, mre, mwe, rwe,
                pcwe ? pcs : 2'd0, show ? aop : 4'd0, show ? asb : 2'd0,
                rwe ? rd : 2'd0, rwe ? wbs : 2'd0};
    endfunction

    function automatic logic [21:0] observe(logic show);
        return mk(bus.state, bus.fault, bus.pc_we, bus.ir_we, bus.mem_re,
                  bus.mem_we, bus.reg_we, bus.pc_src, bus.alu_op,
                  bus.alu_src_b, bus.reg_dst, bus.wb_sel, show);
    endfunction

    function automatic logic [21:0] exp_out(int ph, int k, logic [5:0] op,
        logic [5:0] fn, logic mr, logic z, int flt, logic show);
        logic       pcwe = 1'b0, irwe = 1'b0, mre = 1'b0, mwe = 1'b0, rwe = 1'b0;
        logic [1:0] pcs = 2'd0, rd = 2'd0, wbs = 2'd0;
        logic [5:0] alu = exp_alu(op, fn);
        case (ph)
            0: begin mre = 1'b1; irwe = mr; pcwe = mr; end
            1: if (k == K_J) begin pcwe = 1'b1; pcs = 2'd2; end
            2: begin
                if (k == K_BEQ) begin pcwe = z; pcs = 2'd1; end
                if (k == K_JR)  begin pcwe = 1'b1; pcs = 2'd3; end
            end
            3: begin mre = (k == K_LW); mwe = (k == K_SW); end
            4: begin
                rwe = 1'b1;
                if (k == K_RALU) rd = 2'd1;
                if (k == K_LW)   wbs = 2'd1;
                if (k == K_JAL) begin rd = 2'd2; wbs = 2'd2; pcwe = 1'b1; pcs = 2'd2; end
            end
            default: ;
        endcase
        return mk(3'(ph), 2'(flt), pcwe, irwe, mre, mwe, rwe, pcs,
                  alu[5:2], alu[1:0], rd, wbs, show);
    endfunction

    task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add(input int ph, input int mr, input int flt);
        step_t s;
        s.ph  = ph;
        s.mr  = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
        s.flt = flt;
        plan.push_back(s);
    endtask

    // Expected phase sequence from the latency and wait-timeout rules.
    task automatic build(input int k, input int wf, input int wm);
        plan.delete();
        if (wf >= WAITMAX) begin
            repeat (WAITMAX) add(0, 0, 0);
            repeat (5) add(5, -1, 2);
            return;
        end
        repeat (wf) add(0, 0, 0);
        add(0, 1, 0);
        add(1, -1, 0);
        case (k)
            K_ILL:          repeat (20) add(5, -1, 1);
            K_JAL:          add(4, -1, 0);
            K_BEQ, K_JR:    add(2, -1, 0);
            K_RALU, K_IALU: begin add(2, -1, 0); add(4, -1, 0); end
            K_LW, K_SW: begin
                add(2, -1, 0);
                if (wm >= WAITMAX) begin
                    repeat (WAITMAX) add(3, 0, 0);
                    repeat (5) add(5, -1, 2);
                end else begin
                    repeat (wm) add(3, 0, 0);
                    add(3, 1, 0);
                    if (k == K_LW) add(4, -1, 0);
                end
            end
            default: ;
        endcase
    endtask

    // cur < 0: state before reset is unknown, skip the assertion-cycle check.
    task automatic do_reset(input int cur, input int flt);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'($urandom);
        bus.opcode    = 6'($urandom);
        bus.func      = 6'($urandom);
        #1;
        if (cur >= 0)
            chk("rst_assert", observe(1'b0),
                mk(3'(cur), 2'(flt), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        @(negedge clk);
        #1;
        chk("rst_state", observe(1'b0),
            mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        rst = 1'b0;
        #1;
        chk("rst_quiet", observe(1'b0),
            mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    endtask

    task automatic play(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int abort_at);
        int   k = kind(op, fn);
        logic show;
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(plan[i].ph, plan[i].flt);
                return;
            end
            @(negedge clk);
            if (plan[i].ph == 0 || plan[i].ph == 5) begin
                bus.opcode = 6'($urandom);
                bus.func   = 6'($urandom);
            end else begin
                bus.opcode = op;
                bus.func   = fn;
            end
            bus.mem_ready = plan[i].mr;
            bus.zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            show          = (plan[i].ph == 2) && (k != K_JR);
            #1;
            chk($sformatf("op%02h/%02h step%0d ph%0d", op, fn, i, plan[i].ph), observe(show),
                exp_out(plan[i].ph, k, op, fn, plan[i].mr, bus.zero, plan[i].flt, show));
        end
        if (plan[plan.size()-1].ph == 5) do_reset(5, plan[plan.size()-1].flt);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int wf,
                       input int wm, input int zmode, input int abort_at);
        build(kind(op, fn), wf, wm);
        play(op, fn, zmode, abort_at);
    endtask

    initial begin
        bus.opcode    = 6'd0;
        bus.func      = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset(-1, 0);

        run(6'h00, 6'h21, 0, 0, 0, -1);   // addu
        run(6'h23, 6'h11, 0, 3, 0, -1);   // lw, 3 stalled MEM cycles
        run(6'h04, 6'h00, 0, 0, 1, -1);   // beq taken
        run(6'h04, 6'h00, 0, 0, 0, -1);   // beq not taken
        run(6'h02, 6'h3F, 1, 0, 0, -1);   // j
        run(6'h03, 6'h00, 0, 0, 0, -1);   // jal
        run(6'h00, 6'h08, 0, 0, 0, -1);   // jr
        run(6'h2B, 6'h00, 2, 1, 0, -1);   // sw
        run(6'h0D, 6'h00, 0, 0, 0, -1);   // ori
        run(6'h0F, 6'h00, 0, 0, 0, -1);   // lui
        run(6'h3F, 6'h00, 0, 0, 0, -1);   // illegal opcode
        run(6'h00, 6'h01, 0, 0, 0, -1);   // illegal func
        run(6'h00, 6'h21, WAITMAX, 0, 0, -1); // fetch timeout
        run(6'h23, 6'h00, 0, WAITMAX, 0, -1); // lw MEM timeout
        run(6'h2B, 6'h00, 0, 5, 0, 5);    // reset during sw MEM wait

        for (int n = 0; n < 80; n++) begin
            logic [11:0] e;
            logic [5:0]  op, fn;
            int          r, wf, wm, ab;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (kind(op, fn) != K_ILL);
            end else begin
                e  = legal[$urandom_range(0, 13)];
                op = e[11:6];
                fn = (op == 6'h00) ? e[5:0] : 6'($urandom);
            end
            wf = (r >= 8  && r < 11) ? WAITMAX : $urandom_range(0, 3);
            wm = (r >= 11 && r < 14) ? WAITMAX : $urandom_range(0, 3);
            build(kind(op, fn), wf, wm);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, plan.size() - 1)) : -1;
            play(op, fn, 2, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, max cycles waiting on mem_ready before timeout.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  6  instruction[31:26] from decoder.
REQ-005 SHALL have port func  in  6  instruction[5:0] from decoder.
REQ-006 SHALL have port zero  in  1  ALU result-equals-zero flag.
REQ-007 SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-008 SHALL have port pc_we  out  1  PC register write enable.
REQ-009 SHALL have port pc_src  out  2  0=PC+4, 1=branch target, 2=jump index, 3=rs (jr).
REQ-010 SHALL have port ir_we  out  1  instruction register write enable.
REQ-011 SHALL have port mem_re / mem_we  out  1 each  data/instruction memory read/write strobes.
REQ-012 SHALL have port alu_op  out  4  0=add,1=sub,2=and,3=or,4=slt,5=sll,6=lui.
REQ-013 SHALL have port alu_src_b  out  2  0=rt, 1=sign-ext imm, 2=zero-ext imm.
REQ-014 SHALL have port reg_we  out  1  register file write enable.
REQ-015 SHALL have port reg_dst  out  2  0=rt, 1=rd, 2=r31.
REQ-016 SHALL have port wb_sel  out  2  0=ALU result, 1=memory data, 2=PC+4.
REQ-017 SHALL have port fault  out  2  0=none, 1=illegal instruction, 2=memory timeout; sticky.
REQ-018 SHALL have port state  out  3  current state, debug only.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-020 FETCH: mem_re=1; on mem_ready -> ir_we=1, pc_we=1, pc_src=0 same cycle, go DECODE; else stay.
REQ-021 DECODE: j -> pc_we=1, pc_src=2, go FETCH; jal -> go WB; illegal opcode/func -> HALT, fault=1; otherwise -> EXEC.
REQ-022 Supported: R-type addu,subu,and,or,slt,sll,jr; I-type addiu,ori,lui,lw,sw,beq; J-type j,jal.
REQ-023 EXEC: drive alu_op/alu_src_b per instruction (ori,lui zero-ext; addiu,lw,sw sign-ext); beq -> alu_op=sub, pc_we=zero, pc_src=1, go FETCH; jr -> pc_we=1, pc_src=3, go FETCH; lw/sw -> MEM; others -> WB.
REQ-024 MEM: lw holds mem_re=1, sw holds mem_we=1 until mem_ready; then lw -> WB, sw -> FETCH.
REQ-025 WB: reg_we=1 exactly one cycle; R-type reg_dst=1,wb_sel=0; I-type ALU reg_dst=0,wb_sel=0; lw reg_dst=0,wb_sel=1; jal reg_dst=2,wb_sel=2 plus pc_we=1,pc_src=2; then FETCH.
REQ-026 Latency from FETCH entry (zero-wait memory): j 2, beq/jr 3, jal 3, R/I ALU 4, sw 4, lw 5 cycles.
REQ-027 Wait counter counts consecutive FETCH/MEM cycles with mem_ready=0; reaching MEM_WAIT_MAX -> HALT, fault=2, no strobe that cycle.
REQ-028 HALT: all enables and strobes 0; remain until rst; fault holds.
REQ-029 All enable outputs SHALL be zero in any state/condition not listed above; at most one of reg_we, mem_we, ir_we high per cycle.
REQ-030 Opcode/func SHALL be sampled only in DECODE/EXEC/MEM/WB (IR stable); FETCH ignores them.

Reset
REQ-031 rst high at a clock edge SHALL force state=FETCH, fault=0, wait counter=0, taking precedence over all transitions, including mid-MEM and in HALT.
REQ-032 During and the cycle after reset assertion, pc_we, ir_we, reg_we, mem_we SHALL be 0; mem_re reflects FETCH only after rst deasserts.

Structure
REQ-033 State encodings, opcode/func constants, alu_op/pc_src/wb_sel/reg_dst codes SHALL live in shared package mips_pkg.
REQ-034 Next-state and output decode SHALL be in one module; an optional sub-module ctrl_op_decode (opcode/func -> instruction class, illegal) is natural.

Verification
REQ-035 addu $3,$1,$2, mem_ready=1 -> states 0,1,2,4; reg_we=1 in cycle 4 with reg_dst=1, alu_op=0.
REQ-036 lw with mem_ready low 3 cycles in MEM -> mem_re held 4 cycles, then WB reg_we=1, wb_sel=1; 8 cycles total.
REQ-037 beq with zero=1 then zero=0 -> pc_we=1,pc_src=1 in EXEC first case, pc_we=0 second; both return FETCH.
REQ-038 opcode 0x3F -> HALT after DECODE, fault=1, no enables for 20 cycles; rst -> FETCH, fault=0.
REQ-039 mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> HALT after 15 wait cycles, fault=2.
REQ-040 rst asserted during sw MEM wait -> next cycle state=0, mem_we=0, no register/memory write.
